fifo_umbral: RTL and testbench

- Synchronous single-clock FIFO that services the Fifo_wr/Fifo_rd/Fifo_Data_in stimulus interface and returns Fifo_Data_out.
- It is the responder end of that interface. It buffers LENGTH words of BITNUMBER bits.
- It adds programmable almost-full/almost-empty thresholds for upstream flow control, and a sticky overflow/underflow error.
- It sits between a producer and a consumer in the datapath and is the unit checked by the FIFO test bench.

---
 rtl/fifo_umbral_pkg.sv | 26 ++
 rtl/fifo_mem.sv | 48 ++++
 rtl/fifo_umbral.sv | 118 +++++++++++
 tb/tb_fifo_umbral.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_umbral_pkg.sv
// Shared definitions for the threshold FIFO: default geometry, pointer-width
// derivation, flag bundle and reset values used by both the design and its bench.
package fifo_umbral_pkg;

    localparam int unsigned DEF_BITNUMBER = 8;
    localparam int unsigned DEF_LENGTH    = 8;

    localparam int unsigned RST_DATA  = 0;
    localparam logic        RST_VALID = 1'b0;
    localparam logic        RST_ERROR = 1'b0;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } flags_t;

    localparam flags_t RST_FLAGS = '{full: 1'b0, empty: 1'b1, almost_full: 1'b0, almost_empty: 1'b1};

    // Pointer width for a given depth; depth is always >= 2.
    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Dual-port storage array: synchronous write, registered synchronous read.
// The array itself is never reset; only the read-data register is.
module fifo_mem
    import fifo_umbral_pkg::*;
#(
    parameter int unsigned W     = DEF_BITNUMBER,
    parameter int unsigned DEPTH = DEF_LENGTH,
    parameter int unsigned AW    = addr_width(DEF_LENGTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rdata_d;
    logic [W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read register holds its last word when no read is accepted.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= W'(RST_DATA);
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/fifo_umbral.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds
// and a sticky overflow/underflow error flag.
module fifo_umbral
    import fifo_umbral_pkg::*;
#(
    parameter int unsigned BITNUMBER = DEF_BITNUMBER,
    parameter int unsigned LENGTH    = DEF_LENGTH,
    localparam int unsigned ADDRW    = addr_width(LENGTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 Fifo_wr,
    input  logic                 Fifo_rd,
    input  logic [BITNUMBER-1:0] Fifo_Data_in,
    input  logic [ADDRW:0]       umbral_alto,
    input  logic [ADDRW:0]       umbral_bajo,
    output logic [BITNUMBER-1:0] Fifo_Data_out,
    output logic                 valid_out,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic                 error,
    output logic [ADDRW:0]       count
);

    localparam int unsigned      CNTW     = ADDRW + 1;
    localparam logic [CNTW-1:0]  CNT_FULL = CNTW'(LENGTH);
    localparam logic [ADDRW-1:0] PTR_LAST = ADDRW'(LENGTH - 1);

    logic [ADDRW-1:0] wr_ptr_d, wr_ptr_q;
    logic [ADDRW-1:0] rd_ptr_d, rd_ptr_q;
    logic [CNTW-1:0]  count_d, count_q;
    logic             error_d, error_q;
    logic             valid_d, valid_q;

    flags_t flags_c;
    logic   wr_acc_c;
    logic   rd_acc_c;

    // Flags decode straight from the occupancy register and live thresholds.
    always_comb begin
        flags_c              = RST_FLAGS;
        flags_c.full         = (count_q == CNT_FULL);
        flags_c.empty        = (count_q == '0);
        flags_c.almost_full  = (umbral_alto != '0) && (count_q >= umbral_alto);
        flags_c.almost_empty = (count_q <= umbral_bajo);
    end

    // A write into a full FIFO is still taken when a read frees the slot in the same cycle.
    assign wr_acc_c = Fifo_wr && (!flags_c.full || Fifo_rd);
    assign rd_acc_c = Fifo_rd && !flags_c.empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        error_d  = error_q;
        valid_d  = rd_acc_c;

        if (wr_acc_c) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + ADDRW'(1);
        end
        if (rd_acc_c) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + ADDRW'(1);
        end

        unique case ({wr_acc_c, rd_acc_c})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase

        if ((Fifo_wr && flags_c.full && !Fifo_rd) || (Fifo_rd && flags_c.empty)) begin
            error_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            error_q  <= RST_ERROR;
            valid_q  <= RST_VALID;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            error_q  <= error_d;
            valid_q  <= valid_d;
        end
    end

    fifo_mem #(
        .W     (BITNUMBER),
        .DEPTH (LENGTH),
        .AW    (ADDRW)
    ) u_mem (
        .clk   (clk),
        .rst   (reset),
        .we    (wr_acc_c),
        .waddr (wr_ptr_q),
        .wdata (Fifo_Data_in),
        .re    (rd_acc_c),
        .raddr (rd_ptr_q),
        .rdata (Fifo_Data_out)
    );

    assign full         = flags_c.full;
    assign empty        = flags_c.empty;
    assign almost_full  = flags_c.almost_full;
    assign almost_empty = flags_c.almost_empty;
    assign error        = error_q;
    assign valid_out    = valid_q;
    assign count        = count_q;

endmodule

// File: tb/tb_fifo_umbral.sv
// Bench for fifo_umbral: directed vector table, hand-written reset/threshold
// sequences, then randomized traffic against a queue-based reference model.
module tb_fifo_umbral;
    import fifo_umbral_pkg::*;

    localparam int unsigned LEN = 8;

    typedef struct {
        logic       wr;
        logic       rd;
        logic [7:0] din;
        logic [3:0] cnt;
        logic       valid;
        logic [7:0] dout;
        logic       err;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       Fifo_wr;
    logic       Fifo_rd;
    logic [7:0] Fifo_Data_in;
    logic [3:0] umbral_alto;
    logic [3:0] umbral_bajo;
    logic [7:0] Fifo_Data_out;
    logic       valid_out;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic       error;
    logic [3:0] count;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] mq[$];
    logic       m_err;
    logic       m_valid;
    logic [7:0] m_dout;

    vec_t vecs[$];

    fifo_umbral #(
        .BITNUMBER (8),
        .LENGTH    (LEN)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .Fifo_wr       (Fifo_wr),
        .Fifo_rd       (Fifo_rd),
        .Fifo_Data_in  (Fifo_Data_in),
        .umbral_alto   (umbral_alto),
        .umbral_bajo   (umbral_bajo),
        .Fifo_Data_out (Fifo_Data_out),
        .valid_out     (valid_out),
        .full          (full),
        .empty         (empty),
        .almost_full   (almost_full),
        .almost_empty  (almost_empty),
        .error         (error),
        .count         (count)
    );

    always #5 clk = ~clk;

    function automatic flags_t flags_of(input int cnt, input int alto, input int bajo);
        flags_t f;
        f.full         = (cnt == LEN);
        f.empty        = (cnt == 0);
        f.almost_full  = (alto != 0) && (cnt >= alto);
        f.almost_empty = (cnt <= bajo);
        return f;
    endfunction

    function automatic vec_t mk(input logic wr, input logic rd, input int din, input int cnt,
                                input logic valid, input int dout, input logic err);
        vec_t v;
        v.wr = wr; v.rd = rd; v.din = 8'(din); v.cnt = 4'(cnt);
        v.valid = valid; v.dout = 8'(dout); v.err = err;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s #%0d: got %0h expected %0h (t=%0t)", nm, idx, act, exp, $time);
    endtask

    task automatic chk_all(input string tag, input int idx, input int cnt, input logic valid,
                           input logic [7:0] dout, input logic err);
        flags_t ef;
        ef = flags_of(cnt, int'(umbral_alto), int'(umbral_bajo));
        chk({tag, ".count"}, idx, 32'(count), 32'(cnt));
        chk({tag, ".valid"}, idx, 32'(valid_out), 32'(valid));
        chk({tag, ".dout"},  idx, 32'(Fifo_Data_out), 32'(dout));
        chk({tag, ".error"}, idx, 32'(error), 32'(err));
        chk({tag, ".flags"}, idx, 32'({full, empty, almost_full, almost_empty}), 32'(ef));
    endtask

    task automatic step(input logic wr, input logic rd, input logic [7:0] din);
        Fifo_wr = wr; Fifo_rd = rd; Fifo_Data_in = din;
        @(posedge clk);
        #1;
        Fifo_wr = 1'b0; Fifo_rd = 1'b0;
    endtask

    task automatic model_reset();
        mq.delete();
        m_err = 1'b0; m_valid = 1'b0; m_dout = 8'h00;
    endtask

    // Reference behaviour: a bounded queue with sticky error and 1-cycle read data.
    task automatic model_step(input logic wr, input logic rd, input logic [7:0] din);
        int sz;
        sz = mq.size();
        if (rd && sz == 0) m_err = 1'b1;
        if (wr && sz == LEN && !rd) m_err = 1'b1;
        if (rd && sz > 0) begin
            m_dout = mq.pop_front();
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
        if (wr && (sz < LEN || rd)) mq.push_back(din);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        reset = 1'b1; Fifo_wr = 1'b0; Fifo_rd = 1'b0; Fifo_Data_in = 8'h00;
        umbral_alto = 4'd6; umbral_bajo = 4'd2;

        // Directed vectors
        for (int i = 0; i < 4; i++) vecs.push_back(mk(1, 0, 8'hA + i, i + 1, 0, 0, 0));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 1, 0, 3 - i, 1, 8'hA + i, 0));
        for (int i = 1; i <= 8; i++) vecs.push_back(mk(1, 0, i, i, 0, 8'hD, 0));
        vecs.push_back(mk(1, 0, 9, 8, 0, 8'hD, 1));
        for (int i = 1; i <= 8; i++) vecs.push_back(mk(0, 1, 0, 8 - i, 1, i, 1));
        for (int i = 1; i <= 8; i++) vecs.push_back(mk(1, 0, i, i, 0, 8, 1));
        for (int i = 1; i <= 10; i++) begin
            if (i <= 8) vecs.push_back(mk(0, 1, 0, 8 - i, 1, i, 1));
            else        vecs.push_back(mk(0, 1, 0, 0, 0, 8, 1));
        end
        for (int i = 1; i <= 8; i++) vecs.push_back(mk(1, 0, i, i, 0, 8, 1));
        vecs.push_back(mk(1, 1, 8'hF, 8, 1, 1, 1));
        for (int i = 1; i <= 8; i++) vecs.push_back(mk(0, 1, 0, 8 - i, 1, (i < 8) ? i + 1 : 8'hF, 1));

        // Asynchronous reset state, before any clock edge
        #1;
        chk_all("reset", 0, 0, RST_VALID, 8'(RST_DATA), RST_ERROR);
        chk("reset.flagconst", 0, 32'({full, empty, almost_full, almost_empty}), 32'(RST_FLAGS));
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].wr, vecs[i].rd, vecs[i].din);
            chk_all("vec", i, int'(vecs[i].cnt), vecs[i].valid, vecs[i].dout, vecs[i].err);
        end

        // Thresholds act combinationally with count held at 3
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'h30 + i));
        chk("hold.count", 0, 32'(count), 32'd3);
        umbral_alto = 4'd0;  #1; chk("alto0.af", 0, 32'(almost_full), 32'd0);
        umbral_alto = 4'd3;  #1; chk("alto3.af", 0, 32'(almost_full), 32'd1);
        umbral_alto = 4'd4;  #1; chk("alto4.af", 0, 32'(almost_full), 32'd0);
        umbral_alto = 4'd15; #1; chk("alto15.af", 0, 32'(almost_full), 32'd0);
        umbral_bajo = 4'd15; #1; chk("bajo15.ae", 0, 32'(almost_empty), 32'd1);
        umbral_bajo = 4'd3;  #1; chk("bajo3.ae", 0, 32'(almost_empty), 32'd1);
        umbral_bajo = 4'd2;  #1; chk("bajo2.ae", 0, 32'(almost_empty), 32'd0);
        umbral_alto = 4'd6;

        // Reset between edges discards contents without waiting for a clock
        reset = 1'b1;
        #1;
        chk("midrst.count", 0, 32'(count), 32'd0);
        chk("midrst.empty", 0, 32'(empty), 32'd1);
        chk("midrst.valid", 0, 32'(valid_out), 32'd0);
        chk("midrst.dout",  0, 32'(Fifo_Data_out), 32'd0);
        chk("midrst.error", 0, 32'(error), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1'b1, 1'b0, 8'h05);
        step(1'b0, 1'b1, 8'h00);
        chk_all("post_rst", 0, 0, 1'b1, 8'h05, 1'b0);

        // Simultaneous read+write on empty: write taken, read underflows
        step(1'b1, 1'b1, 8'h77);
        chk_all("emptyrw", 0, 1, 1'b0, 8'h05, 1'b1);
        step(1'b0, 1'b1, 8'h00);
        chk_all("emptyrw_rd", 0, 0, 1'b1, 8'h77, 1'b1);

        // Randomized traffic against the reference model
        for (int ep = 0; ep < 4; ep++) begin
            int pw, pr;
            pw = (ep == 0) ? 70 : (ep == 1) ? 30 : (ep == 2) ? 50 : 90;
            pr = (ep == 0) ? 30 : (ep == 1) ? 70 : (ep == 2) ? 50 : 90;
            apply_reset();
            for (int c = 0; c < 400; c++) begin
                logic       wr, rd;
                logic [7:0] din;
                wr  = ($urandom_range(0, 99) < pw);
                rd  = ($urandom_range(0, 99) < pr);
                din = 8'($urandom);
                umbral_alto = 4'($urandom_range(0, 15));
                umbral_bajo = 4'($urandom_range(0, 15));
                step(wr, rd, din);
                model_step(wr, rd, din);
                chk_all("rand", ep * 1000 + c, mq.size(), m_valid, m_dout, m_err);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
